led_bounce_checker: RTL and testbench

Receive-side checker for the 8-LED bounce pattern that the LED cycle block drives: 0, 1, …, 7, 6, …, 1, 0, … with exactly one light on per step. It samples the 8-bit light bus on a sample strobe and locks onto the sequence. Once locked it reports the current position and direction, and it flags and counts any step that breaks the pattern. It sits beside the LED driver as a self-check, and its status outputs go to HEX displays or to a bench scoreboard.

---
 rtl/led_bounce_checker.sv | 150 +++++++++++++++
 tb/tb_led_bounce_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_bounce_checker.sv
// Receive-side checker for the 8-LED bounce pattern (0..7..0 ...).
// It locks onto the pattern, tracks position and direction, and flags and counts violations.
module led_bounce_checker #(
    parameter int CNT_W = 8
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [7:0]       lights,
    output logic [2:0]       position,
    output logic             direction,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] reversal_count
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [2:0] pos_nxt;
    logic       dir_nxt;
    logic       err_nxt;
    logic       err_inc;
    logic       rev_inc;

    logic       valid;
    logic [2:0] idx;
    logic       up_adj;
    logic       dn_adj;
    logic [2:0] exp_idx;
    logic       turn;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign valid = is_onehot(lights);
    assign idx   = encode(lights);

    // Guard the ends so 3-bit wraparound never counts as adjacency.
    assign up_adj = (position != 3'd7) && (idx == position + 3'd1);
    assign dn_adj = (position != 3'd0) && (idx == position - 3'd1);

    always_comb begin
        exp_idx = 3'd0;
        turn    = 1'b0;
        if (!direction) begin
            if (position == 3'd7) begin
                exp_idx = 3'd6;
                turn    = 1'b1;
            end else begin
                exp_idx = position + 3'd1;
            end
        end else begin
            if (position == 3'd0) begin
                exp_idx = 3'd1;
                turn    = 1'b1;
            end else begin
                exp_idx = position - 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = position;
        dir_nxt   = direction;
        err_nxt   = 1'b0;
        err_inc   = 1'b0;
        rev_inc   = 1'b0;
        if (sample_en) begin
            case (state)
                SEARCH: begin
                    if (valid) begin
                        pos_nxt   = idx;
                        state_nxt = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (!valid) begin
                        state_nxt = SEARCH;
                    end else begin
                        pos_nxt = idx;
                        if (up_adj) begin
                            dir_nxt   = 1'b0;
                            state_nxt = LOCKED;
                        end else if (dn_adj) begin
                            dir_nxt   = 1'b1;
                            state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (valid && (idx == exp_idx)) begin
                        pos_nxt = idx;
                        if (turn) begin
                            dir_nxt = ~direction;
                            rev_inc = 1'b1;
                        end
                    end else begin
                        err_nxt = 1'b1;
                        err_inc = 1'b1;
                        if (valid) begin
                            pos_nxt   = idx;
                            state_nxt = ACQUIRE;
                        end else begin
                            state_nxt = SEARCH;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state          <= SEARCH;
            position       <= 3'd0;
            direction      <= 1'b0;
            locked         <= 1'b0;
            error          <= 1'b0;
            error_count    <= '0;
            reversal_count <= '0;
        end else begin
            state     <= state_nxt;
            position  <= pos_nxt;
            direction <= dir_nxt;
            locked    <= (state_nxt == LOCKED);
            error     <= err_nxt;
            if (err_inc) error_count <= sat_inc(error_count);
            if (rev_inc) reversal_count <= sat_inc(reversal_count);
        end
    end

endmodule

// File: tb/tb_led_bounce_checker.sv
// Self-checking bench for led_bounce_checker (CNT_W=2 so saturation is reachable).
// Table-driven vectors plus hand sequences; expectations flow through a scoreboard queue.
module tb_led_bounce_checker;

    localparam int CNT_W = 2;

    logic             inclk = 1'b0;
    logic             reset = 1'b0;
    logic             sample_en = 1'b0;
    logic [7:0]       lights = 8'd0;
    logic [2:0]       position;
    logic             direction;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] reversal_count;

    led_bounce_checker #(.CNT_W(CNT_W)) dut (
        .inclk          (inclk),
        .reset          (reset),
        .sample_en      (sample_en),
        .lights         (lights),
        .position       (position),
        .direction      (direction),
        .locked         (locked),
        .error          (error),
        .error_count    (error_count),
        .reversal_count (reversal_count)
    );

    always #5 inclk = ~inclk;

    typedef struct packed {
        logic [2:0]       pos;
        logic             dir;
        logic             lck;
        logic             err;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] rc;
    } out_t;

    typedef struct {
        logic       rst;
        logic [7:0] lights;
        out_t       o;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic out_t mk(input int p, input int d, input int l, input int e,
                                input int ec, input int rc);
        out_t r;
        r.pos = 3'(p);
        r.dir = 1'(d);
        r.lck = 1'(l);
        r.err = 1'(e);
        r.ec  = CNT_W'(ec);
        r.rc  = CNT_W'(rc);
        return r;
    endfunction

    task automatic add(input int r, input logic [7:0] l, input int p, input int d,
                       input int lk, input int e, input int ec, input int rc);
        vec_t v;
        v.rst    = 1'(r);
        v.lights = l;
        v.o      = mk(p, d, lk, e, ec, rc);
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input out_t e);
        out_t a;
        a = '{position, direction, locked, error, error_count, reversal_count};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got pos=%0d dir=%0d lck=%0d err=%0d ec=%0d rc=%0d, want pos=%0d dir=%0d lck=%0d err=%0d ec=%0d rc=%0d",
                     name, a.pos, a.dir, a.lck, a.err, a.ec, a.rc,
                     e.pos, e.dir, e.lck, e.err, e.ec, e.rc);
        end
    endtask

    // One cycle: drive on the falling edge, queue the expectation, check after the rising edge.
    task automatic cycle(input logic en, input logic [7:0] l, input out_t e, input string name);
        @(negedge inclk);
        sample_en = en;
        lights    = l;
        sb.push_back(e);
        @(posedge inclk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            compare(name, sb.pop_front());
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge inclk);
        sample_en = 1'b0;
        reset = 1'b1;
        #1;
        compare(name, mk(0, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int   cur;
        int   d;
        int   nxt;
        int   turns;
        int   ec;
        out_t last;

        // rst, lights, pos, dir, locked, error, err_cnt, rev_cnt
        add(1, 8'h01, 0, 0, 0, 0, 0, 0);
        add(0, 8'h02, 1, 0, 1, 0, 0, 0);
        add(0, 8'h04, 2, 0, 1, 0, 0, 0);
        add(0, 8'h08, 3, 0, 1, 0, 0, 0);
        add(0, 8'h10, 4, 0, 1, 0, 0, 0);
        add(0, 8'h20, 5, 0, 1, 0, 0, 0);
        add(0, 8'h40, 6, 0, 1, 0, 0, 0);
        add(0, 8'h80, 7, 0, 1, 0, 0, 0);
        add(0, 8'h40, 6, 1, 1, 0, 0, 1);
        add(0, 8'h20, 5, 1, 1, 0, 0, 1);
        add(0, 8'h10, 4, 1, 1, 0, 0, 1);
        add(0, 8'h08, 3, 1, 1, 0, 0, 1);
        add(0, 8'h04, 2, 1, 1, 0, 0, 1);
        add(0, 8'h02, 1, 1, 1, 0, 0, 1);
        add(0, 8'h01, 0, 1, 1, 0, 0, 1);
        add(0, 8'h02, 1, 0, 1, 0, 0, 2);
        // mid-stream acquisition going down, then a violation back into ACQUIRE
        add(1, 8'h20, 5, 0, 0, 0, 0, 0);
        add(0, 8'h10, 4, 1, 1, 0, 0, 0);
        add(0, 8'h08, 3, 1, 1, 0, 0, 0);
        add(0, 8'h10, 4, 1, 0, 1, 1, 0);
        add(0, 8'h08, 3, 1, 1, 0, 1, 0);
        add(0, 8'h04, 2, 1, 1, 0, 1, 0);
        add(0, 8'h02, 1, 1, 1, 0, 1, 0);
        add(0, 8'h01, 0, 1, 1, 0, 1, 0);
        add(0, 8'h02, 1, 0, 1, 0, 1, 1);
        add(0, 8'h04, 2, 0, 1, 0, 1, 1);
        add(0, 8'h08, 3, 0, 1, 0, 1, 1);
        // two-hot while locked: SEARCH; 0x00 silent; 0x04 only acquires (proves SEARCH)
        add(0, 8'h18, 3, 0, 0, 1, 2, 1);
        add(0, 8'h00, 3, 0, 0, 0, 2, 1);
        add(0, 8'h04, 2, 0, 0, 0, 2, 1);
        add(0, 8'h08, 3, 0, 1, 0, 2, 1);
        add(0, 8'h10, 4, 0, 1, 0, 2, 1);
        add(0, 8'h20, 5, 0, 1, 0, 2, 1);
        add(0, 8'h40, 6, 0, 1, 0, 2, 1);
        add(0, 8'h80, 7, 0, 1, 0, 2, 1);
        // endpoint repeat, then 7->6 relock counts no reversal
        add(0, 8'h80, 7, 0, 0, 1, 3, 1);
        add(0, 8'h40, 6, 1, 1, 0, 3, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset($sformatf("reset_vals_%0d", i));
            cycle(1'b1, tbl[i].lights, tbl[i].o, $sformatf("vec_%0d", i));
        end

        // saturation of error_count: five relock+violate rounds
        do_reset("reset_before_sat");
        ec = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h01, mk(0, 0, 0, 0, ec, 0), $sformatf("sat_acq_%0d", k));
            cycle(1'b1, 8'h02, mk(1, 0, 1, 0, ec, 0), $sformatf("sat_lock_%0d", k));
            ec = (ec < 3) ? ec + 1 : 3;
            cycle(1'b1, 8'h00, mk(1, 0, 0, 1, ec, 0), $sformatf("sat_err_%0d", k));
            cycle(1'b0, 8'h04, mk(1, 0, 0, 0, ec, 0), $sformatf("sat_idle_%0d", k));
        end

        // six turnarounds, then walk to position 5
        cycle(1'b1, 8'h01, mk(0, 0, 0, 0, 3, 0), "rev_acq");
        cycle(1'b1, 8'h02, mk(1, 0, 1, 0, 3, 0), "rev_lock");
        cur = 1;
        d = 0;
        turns = 0;
        while (turns < 6 || cur != 5) begin
            if (d == 0) begin
                if (cur == 7) begin
                    nxt = 6;
                    d = 1;
                    turns++;
                end else begin
                    nxt = cur + 1;
                end
            end else begin
                if (cur == 0) begin
                    nxt = 1;
                    d = 0;
                    turns++;
                end else begin
                    nxt = cur - 1;
                end
            end
            cur = nxt;
            last = mk(cur, d, 1, 0, 3, (turns > 3) ? 3 : turns);
            cycle(1'b1, 8'(1 << cur), last, $sformatf("rev_step_t%0d_p%0d", turns, cur));
        end
        cycle(1'b0, 8'h00, last, "rev_idle_hold");

        // asynchronous reset mid-cycle, overlapping a strobe
        @(negedge inclk);
        sample_en = 1'b1;
        lights = 8'h10;
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset", mk(0, 0, 0, 0, 0, 0));
        @(posedge inclk);
        #1;
        compare("reset_over_strobe", mk(0, 0, 0, 0, 0, 0));
        @(negedge inclk);
        reset = 1'b0;
        cycle(1'b1, 8'h40, mk(6, 0, 0, 0, 0, 0), "post_reset_search");
        cycle(1'b1, 8'h20, mk(5, 1, 1, 0, 0, 0), "post_reset_lock");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
